// File: rtl/run_recon.sv
`default_nettype none
// ============================================================================
//  Module   : run_recon
//  Purpose  : JPEG-LS run-interruption sample reconstructor. Rebuilds Ix from
//             the decoded error and the Ra/Rb neighbours. It uses a two-stage
//             valid/ready pipeline that can accept one sample per clock.
//  Revision : 1.0  initial release
// ============================================================================
module run_recon (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              in_ready,
  input  logic signed [8:0] Ra,
  input  logic signed [8:0] Rb,
  input  logic signed [8:0] Errval,
  input  logic              RItype_in,
  output logic signed [8:0] Ix,
  output logic              RItype,
  output logic              en_out,
  input  logic              out_ready,
  output logic              ri_mismatch
);

  localparam logic signed [9:0] C_MOD = 10'sd256;
  localparam logic signed [9:0] C_MAX = 10'sd255;

  logic              v1;
  logic              v2;
  logic              adv1;
  logic              adv2;
  logic              same;
  logic signed [8:0] px1;
  logic signed [8:0] err1;
  logic              sgn1;
  logic              rit1;
  logic signed [9:0] sum;
  logic signed [9:0] wrapped;

  // Each stage advances when it is empty or when the stage after it drains.
  // in_ready never depends on en, so the upstream logic has no combinational loop.
  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign en_out   = v2;
  assign same     = (Ra == Rb);

  // Apply the error with the sign chosen in stage 1, then fold the result back into 0..255.
  always_comb begin
    sum     = '0;
    wrapped = '0;
    if (sgn1) begin
      sum = {px1[8], px1} - {err1[8], err1};
    end else begin
      sum = {px1[8], px1} + {err1[8], err1};
    end
    if (sum < 10'sd0) begin
      wrapped = sum + C_MOD;
    end else if (sum > C_MAX) begin
      wrapped = sum - C_MOD;
    end else begin
      wrapped = sum;
    end
  end

  // Stage 1: pick the predictor and sign on input transfer, and track RItype disagreement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1          <= 1'b0;
      px1         <= '0;
      err1        <= '0;
      sgn1        <= 1'b0;
      rit1        <= 1'b0;
      ri_mismatch <= 1'b0;
    end else if (adv1) begin
      v1 <= en;
      if (en) begin
        px1  <= same ? Ra : Rb;
        sgn1 <= (Ra > Rb);
        err1 <= Errval;
        rit1 <= same;
        if (RItype_in != same) begin
          ri_mismatch <= 1'b1;
        end
      end
    end
  end

  // Stage 2: register the reconstructed sample. Its data holds while the stage is stalled or empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v2     <= 1'b0;
      Ix     <= '0;
      RItype <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        Ix     <= 9'(wrapped);
        RItype <= rit1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_recon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_recon
//  Purpose  : Self-checking bench for run_recon. Directed cases use literal
//             expectations. Random round-trip traffic uses a queue-based
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_run_recon;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              in_ready;
  logic signed [8:0] Ra;
  logic signed [8:0] Rb;
  logic signed [8:0] Errval;
  logic              RItype_in;
  logic signed [8:0] Ix;
  logic              RItype;
  logic              en_out;
  logic              out_ready;
  logic              ri_mismatch;

  run_recon dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in_ready    (in_ready),
    .Ra          (Ra),
    .Rb          (Rb),
    .Errval      (Errval),
    .RItype_in   (RItype_in),
    .Ix          (Ix),
    .RItype      (RItype),
    .en_out      (en_out),
    .out_ready   (out_ready),
    .ri_mismatch (ri_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ix;
    int rit;
    int orig;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cur_orig  = -1;
  int   delivered = 0;
  bit   model_mm  = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_ix;
  int   prev_rit;
  bit   rand_or   = 1'b0;

  // Reference model: the inverse of the encoder's run-interruption error mapping, reduced modulo 256.
  function automatic int model_ix(int ra, int rb, int err);
    int s;
    if (ra == rb)     s = ra + err;
    else if (ra > rb) s = rb - err;
    else              s = rb + err;
    return ((s % 256) + 256) % 256;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then record the transfers that the coming edge will perform.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      model_mm   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("ri_mismatch", int'(ri_mismatch), int'(model_mm));
      if (prev_stall) begin
        check("stall_valid", int'(en_out), 1);
        check("stall_ix", int'(Ix), prev_ix);
        check("stall_rit", int'(RItype), prev_rit);
      end
      if (en_out) begin
        check("out_has_expect", int'(q.size() > 0), 1);
        if (out_ready && q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("Ix", int'(Ix), e.ix);
          check("RItype", int'(RItype), e.rit);
          if (e.orig >= 0) check("roundtrip", int'(Ix), e.orig);
          delivered++;
        end
      end
      prev_stall = en_out && !out_ready;
      prev_ix    = int'(Ix);
      prev_rit   = int'(RItype);
      if (en && in_ready) begin
        exp_t n;
        n.ix   = model_ix(int'(Ra), int'(Rb), int'(Errval));
        n.rit  = int'(Ra == Rb);
        n.orig = cur_orig;
        q.push_back(n);
        if (RItype_in != (Ra == Rb)) model_mm = 1'b1;
      end
    end
  end

  // Random backpressure during the round-trip phase.
  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end
  end

  task automatic send(int ra, int rb, int err, bit rit, int orig);
    int n;
    Ra        = 9'(ra);
    Rb        = 9'(rb);
    Errval    = 9'(err);
    RItype_in = rit;
    cur_orig  = orig;
    en        = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en       = 1'b0;
    cur_orig = -1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int ra, rb, ix, err;
    reset     = 1'b0;
    en        = 1'b0;
    Ra        = '0;
    Rb        = '0;
    Errval    = '0;
    RItype_in = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_en_out", int'(en_out), 0);
    check("rst_ix", int'(Ix), 0);
    check("rst_rit", int'(RItype), 0);
    check("rst_mm", int'(ri_mismatch), 0);

    // Basic modes, back-to-back, two-cycle latency
    send(100, 100, 5, 1'b1, -1);
    check("lat_not_early", int'(en_out), 0);
    send(120, 80, -3, 1'b0, -1);
    check("basic0_valid", int'(en_out), 1);
    check("basic0_ix", int'(Ix), 105);
    check("basic0_rit", int'(RItype), 1);
    send(50, 90, 7, 1'b0, -1);
    check("basic1_valid", int'(en_out), 1);
    check("basic1_ix", int'(Ix), 83);
    check("basic1_rit", int'(RItype), 0);
    idle();
    @(posedge clk);
    #1;
    check("basic2_valid", int'(en_out), 1);
    check("basic2_ix", int'(Ix), 97);
    drain();

    // Wrap-around
    send(250, 250, 10, 1'b1, -1);
    send(3, 3, -10, 1'b1, -1);
    check("wrap0_ix", int'(Ix), 4);
    send(200, 10, 20, 1'b0, -1);
    check("wrap1_ix", int'(Ix), 249);
    idle();
    @(posedge clk);
    #1;
    check("wrap2_ix", int'(Ix), 246);
    drain();

    // Backpressure: two samples fill the pipe and the third is held off
    d0        = delivered;
    out_ready = 1'b0;
    send(30, 30, 4, 1'b1, -1);
    send(90, 60, 5, 1'b0, -1);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_head_valid", int'(en_out), 1);
    check("bp_head_ix", int'(Ix), 34);
    Ra = 9'(10); Rb = 9'(200); Errval = -9'sd20; RItype_in = 1'b0; en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_stall_in_ready", int'(in_ready), 0);
      check("bp_stall_ix", int'(Ix), 34);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", int'(in_ready), 1);
    send(10, 200, -20, 1'b0, -1);
    send(0, 0, -1, 1'b1, -1);
    send(255, 0, 3, 1'b0, -1);
    send(128, 128, 127, 1'b1, -1);
    idle();
    drain();
    check("bp_delivered", delivered - d0, 6);

    // Sticky RItype mismatch
    send(40, 40, 0, 1'b0, -1);
    idle();
    check("mm_set", int'(ri_mismatch), 1);
    send(60, 60, 1, 1'b1, -1);
    send(70, 20, 3, 1'b0, -1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("mm_sticky", int'(ri_mismatch), 1);

    // Reset with both stages occupied
    send(10, 10, 1, 1'b1, -1);
    send(20, 20, 2, 1'b1, -1);
    do_reset();
    check("mid_rst_en_out", int'(en_out), 0);
    check("mid_rst_ix", int'(Ix), 0);
    check("mid_rst_mm", int'(ri_mismatch), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    send(30, 40, 5, 1'b0, -1);
    idle();
    check("post_rst_not_early", int'(en_out), 0);
    @(posedge clk);
    #1;
    check("post_rst_valid", int'(en_out), 1);
    check("post_rst_ix", int'(Ix), 45);
    drain();

    // Random round-trip through the encoder equations with random backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom_range(0, 255);
      rb = (($urandom % 4) == 0) ? ra : $urandom_range(0, 255);
      ix = $urandom_range(0, 255);
      if (ra == rb)     err = ix - ra;
      else if (ra > rb) err = rb - ix;
      else              err = ix - rb;
      if (($urandom % 2) == 0) begin
        if (err > 127)       err = err - 256;
        else if (err < -128) err = err + 256;
      end
      send(ra, rb, err, ra == rb, ix);
      if (($urandom % 8) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    rand_or = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    check("rt_no_mismatch", int'(ri_mismatch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
